// File: rtl/usb_tx_engine.sv
// USB low/full-speed packet transmitter: bit timer, sequencing FSM, field shifter,
// CRC16, bit stuffing and NRZI line encoding in one block.
`timescale 1ns / 1ps

module usb_tx_engine #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned LEN_W        = 7,
    parameter bit          IDLE_J_DP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dp,
    output logic             dm,
    output logic             tx_oe,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    typedef enum logic [3:0] {
        StIdle, StSync, StPid, StData, StCrcLo, StCrcHi, StAbort, StEopSe0, StEopJ
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         sh_q, sh_d;
    logic [3:0]         pid_q, pid_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [15:0]        crc_q, crc_d;
    logic [2:0]         ones_q, ones_d;
    logic               nrzi_q, nrzi_d;     // 1 = J, 0 = K
    logic               aborted_q, aborted_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic strobe, stuffable, fetch, place, pbit, pcrc;

    assign strobe    = (state_q != StIdle) && (cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign stuffable = (state_q == StSync) || (state_q == StPid) || (state_q == StData) ||
                       (state_q == StCrcLo) || (state_q == StCrcHi);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Datapath registers: timer, shifter, counters, CRC and line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            pid_q     <= '0;
            rem_q     <= '0;
            crc_q     <= '0;
            ones_q    <= '0;
            nrzi_q    <= 1'b1;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            pid_q     <= pid_d;
            rem_q     <= rem_d;
            crc_q     <= crc_d;
            ones_q    <= ones_d;
            nrzi_q    <= nrzi_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state: on each strobe pick the next line bit (stuff, field bit or new field)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        pid_d     = pid_q;
        rem_d     = rem_q;
        crc_d     = crc_q;
        ones_d    = ones_q;
        nrzi_d    = nrzi_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fetch     = 1'b0;
        place     = 1'b0;
        pbit      = 1'b0;
        pcrc      = 1'b0;

        if (state_q == StIdle) begin
            cnt_d = '0;
            // Start is blocked during the done/err pulse cycle
            if (tx_start && !done_q && !err_q) begin
                state_d   = StSync;
                pid_d     = tx_pid;
                rem_d     = tx_len;
                sh_d      = 8'h80;
                bit_d     = '0;
                crc_d     = 16'hFFFF;
                ones_d    = '0;
                aborted_d = 1'b0;
                place     = 1'b1;
                pbit      = 1'b0;
            end
        end else begin
            cnt_d = strobe ? '0 : cnt_q + 1'b1;
            if (strobe) begin
                if (stuffable && (ones_q == 3'd6)) begin
                    // Stuffed zero: shifter and CRC hold
                    place = 1'b1;
                    pbit  = 1'b0;
                end else begin
                    unique case (state_q)
                        StSync, StPid, StData, StCrcLo, StCrcHi: begin
                            if (bit_q != 3'd7) begin
                                bit_d = bit_q + 3'd1;
                                place = 1'b1;
                                pbit  = sh_q[bit_q + 3'd1];
                                pcrc  = (state_q == StData);
                            end else begin
                                bit_d = '0;
                                unique case (state_q)
                                    StSync: begin
                                        state_d = StPid;
                                        sh_d    = {~pid_q, pid_q};
                                    end
                                    StPid, StData: begin
                                        if ((state_q == StPid) && (pid_q[1:0] != 2'b11)) begin
                                            state_d = StEopSe0;
                                        end else if (rem_q != '0) begin
                                            fetch = 1'b1;
                                        end else begin
                                            state_d = StCrcLo;
                                            sh_d    = ~crc_q[7:0];
                                        end
                                    end
                                    StCrcLo: begin
                                        state_d = StCrcHi;
                                        sh_d    = ~crc_q[15:8];
                                    end
                                    default: state_d = StEopSe0;
                                endcase
                                if (fetch) begin
                                    if (data_valid) begin
                                        state_d = StData;
                                        sh_d    = data_in;
                                        rem_d   = rem_q - 1'b1;
                                    end else begin
                                        state_d   = StAbort;
                                        aborted_d = 1'b1;
                                    end
                                end
                                if ((state_d == StPid) || (state_d == StData) ||
                                    (state_d == StCrcLo) || (state_d == StCrcHi)) begin
                                    place = 1'b1;
                                    pbit  = sh_d[0];
                                    pcrc  = (state_d == StData);
                                end
                            end
                        end
                        StAbort: begin
                            // Line holds for 8 bit times: unstuffed ones
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) state_d = StEopSe0;
                        end
                        StEopSe0: begin
                            if (bit_q == 3'd0) begin
                                bit_d = 3'd1;
                            end else begin
                                bit_d   = '0;
                                state_d = StEopJ;
                                nrzi_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = StIdle;
                            done_d  = ~aborted_q;
                            err_d   = aborted_q;
                        end
                    endcase
                end
            end
        end

        // Commit a placed bit: NRZI, ones run and (payload only) CRC
        if (place) begin
            nrzi_d = pbit ? nrzi_q : ~nrzi_q;
            ones_d = pbit ? ones_q + 3'd1 : 3'd0;
            if (pcrc) begin
                crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ pbit) ? 16'hA001 : 16'h0000);
            end
        end
    end

    // Outputs: line drive from NRZI level, handshake and status pulses
    always_comb begin
        tx_busy    = (state_q != StIdle);
        tx_oe      = tx_busy;
        data_ready = fetch & data_valid;
        tx_done    = done_q;
        tx_err     = err_q;
        if (state_q == StEopSe0) begin
            dp = 1'b0;
            dm = 1'b0;
        end else begin
            dp = nrzi_q ? IDLE_J_DP : ~IDLE_J_DP;
            dm = nrzi_q ? ~IDLE_J_DP : IDLE_J_DP;
        end
    end

endmodule

// File: tb/tb_usb_tx_engine.sv
// Scoreboard bench for usb_tx_engine: an FS instance and an LS instance with swapped polarity.
`timescale 1ns / 1ps

module tb_usb_tx_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tx_start, data_valid, sel;
    logic [3:0] tx_pid;
    logic [6:0] tx_len;
    logic [7:0] data_in;

    logic dr0, dp0, dm0, oe0, bz0, dn0, er0;
    logic dr1, dp1, dm1, oe1, bz1, dn1, er1;

    usb_tx_engine #(.CLKS_PER_BIT(8), .LEN_W(7), .IDLE_J_DP(1'b1)) u_fs (
        .clk(clk), .rst(rst), .tx_start(tx_start & ~sel), .tx_pid(tx_pid), .tx_len(tx_len),
        .data_in(data_in), .data_valid(data_valid), .data_ready(dr0), .dp(dp0), .dm(dm0),
        .tx_oe(oe0), .tx_busy(bz0), .tx_done(dn0), .tx_err(er0)
    );

    usb_tx_engine #(.CLKS_PER_BIT(4), .LEN_W(7), .IDLE_J_DP(1'b0)) u_ls (
        .clk(clk), .rst(rst), .tx_start(tx_start & sel), .tx_pid(tx_pid), .tx_len(tx_len),
        .data_in(data_in), .data_valid(data_valid), .data_ready(dr1), .dp(dp1), .dm(dm1),
        .tx_oe(oe1), .tx_busy(bz1), .tx_done(dn1), .tx_err(er1)
    );

    wire [6:0] obs_fs = {dp0, dm0, oe0, bz0, dr0, dn0, er0};
    wire [6:0] obs_ls = {dp1, dm1, oe1, bz1, dr1, dn1, er1};
    wire [6:0] obs7   = sel ? obs_ls : obs_fs;
    wire [5:0] obs6   = {obs7[6:3], obs7[1:0]};
    wire       obs_rdy = obs7[2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int          cpb;
    bit          jdp;
    logic [1:0]  exp_q[$];
    int          exp_cycles, exp_ready;
    bit          exp_abort;
    int          m_ones;
    bit          m_lvl;
    logic [7:0]  src[$];
    int          src_idx;
    int          done_c, nready;

    function automatic logic [1:0] sym(input bit lvl);
        return lvl ? {jdp, ~jdp} : {~jdp, jdp};
    endfunction

    task automatic emit_bit(input bit b);
        if (!b) m_lvl = ~m_lvl;
        exp_q.push_back(sym(m_lvl));
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == 6) begin
            m_lvl = ~m_lvl;
            exp_q.push_back(sym(m_lvl));
            m_ones = 0;
        end
    endtask

    // Expected per-bit line symbols; CRC kept MSB-first as in the USB serial generator
    task automatic model_packet(input logic [3:0] pid, input int len);
        logic [15:0] c;
        logic [7:0]  x;
        bit          fb;
        exp_q.delete();
        m_ones = 0; m_lvl = 1'b1; exp_abort = 1'b0; exp_ready = 0; c = 16'hFFFF;
        x = 8'h80;
        for (int i = 0; i < 8; i++) emit_bit(x[i]);
        x = {~pid, pid};
        for (int i = 0; i < 8; i++) emit_bit(x[i]);
        if (pid[1:0] == 2'b11) begin
            for (int k = 0; k < len && !exp_abort; k++) begin
                if (k < src.size()) begin
                    x = src[k];
                    exp_ready++;
                    for (int i = 0; i < 8; i++) begin
                        fb = c[15] ^ x[i];
                        c  = {c[14:0], 1'b0};
                        if (fb) c = c ^ 16'h8005;
                        emit_bit(x[i]);
                    end
                end else begin
                    for (int i = 0; i < 8; i++) exp_q.push_back(sym(m_lvl));
                    exp_abort = 1'b1;
                end
            end
            if (!exp_abort) for (int i = 0; i < 16; i++) emit_bit(~c[15-i]);
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(sym(1'b1));
        exp_cycles = 1 + cpb * exp_q.size();
    endtask

    task automatic drive_src();
        data_valid = (src_idx < src.size());
        data_in    = data_valid ? src[src_idx] : 8'h00;
    endtask

    task automatic run_packet(input string name, input logic [3:0] pid, input int len,
                              input int repulse);
        logic [5:0] expv;
        logic [1:0] s;
        bit         rdy;
        int         tot;
        model_packet(pid, len);
        tot = exp_cycles;
        src_idx = 0; nready = 0; done_c = -1;
        @(posedge clk); #1;
        tx_pid = pid; tx_len = 7'(len); tx_start = 1'b1; drive_src();
        @(posedge clk); #1;
        tx_start = 1'b0;
        for (int c = 1; c <= tot + 2; c++) begin
            tx_start = (c == repulse);
            if (c == repulse) tx_pid = ~pid;
            @(negedge clk);
            s    = (exp_q.size() > 0) ? exp_q[0] : sym(1'b1);
            expv = {s, c < tot, c < tot, (c == tot) && !exp_abort, (c == tot) && exp_abort};
            n_cmp++;
            if (obs6 !== expv) begin
                n_bad++;
                $display("FAIL %s line/status c=%0d: got %b want %b", name, c, obs6, expv);
            end
            rdy = obs_rdy;
            if (rdy) nready++;
            if ((obs6[1] | obs6[0]) && done_c < 0) done_c = c;
            if ((c % cpb) == 0 && exp_q.size() > 0) s = exp_q.pop_front();
            @(posedge clk); #1;
            if (rdy) begin
                src_idx++;
                drive_src();
            end
        end
        tx_start = 1'b0;
        tx_pid   = pid;
        n_cmp++;
        if (nready !== exp_ready) begin
            n_bad++;
            $display("FAIL %s data_ready count: got %0d want %0d", name, nready, exp_ready);
        end
    endtask

    task automatic check_done_at(input string name, input int want);
        n_cmp++;
        if (done_c !== want) begin
            n_bad++;
            $display("FAIL %s end pulse cycle: got %0d want %0d", name, done_c, want);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b1; tx_start = 1'b1; tx_pid = 4'b0010; tx_len = '0;
        data_in = '0; data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_fs !== 7'b1000000) begin
            n_bad++; $display("FAIL reset_fs: got %b want %b", obs_fs, 7'b1000000);
        end
        n_cmp++;
        if (obs_ls !== 7'b0100000) begin
            n_bad++; $display("FAIL reset_ls: got %b want %b", obs_ls, 7'b0100000);
        end
        tx_start = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_fs !== 7'b1000000) begin
            n_bad++; $display("FAIL idle_fs: got %b want %b", obs_fs, 7'b1000000);
        end
        n_cmp++;
        if (obs_ls !== 7'b0100000) begin
            n_bad++; $display("FAIL idle_ls: got %b want %b", obs_ls, 7'b0100000);
        end
    endtask

    task automatic test_ack();
        sel = 1'b0; cpb = 8; jdp = 1'b1; src.delete();
        run_packet("ack", 4'b0010, 0, 0);
        check_done_at("ack", 153);
    endtask

    task automatic test_data_empty();
        sel = 1'b0; cpb = 8; jdp = 1'b1; src.delete();
        run_packet("data0_len0", 4'b0011, 0, 0);
        check_done_at("data0_len0", 1 + 8 * 35);
    endtask

    task automatic test_stuffing();
        sel = 1'b0; cpb = 8; jdp = 1'b1;
        src = '{8'hFF, 8'hFF};
        run_packet("data0_ffff", 4'b0011, 2, 0);
    endtask

    task automatic test_underrun();
        sel = 1'b0; cpb = 8; jdp = 1'b1;
        src = '{8'h5A};
        run_packet("underrun", 4'b1011, 3, 0);
        n_cmp++;
        if (nready !== 1) begin
            n_bad++; $display("FAIL underrun ready pulses: got %0d want 1", nready);
        end
        check_done_at("underrun", 1 + 8 * 35);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; cpb = 8; jdp = 1'b1;
        src = '{8'h01};
        run_packet("restart_ignored", 4'b0011, 1, 40);
        src.delete();
        run_packet("b2b_ack", 4'b0010, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit rdy;
        sel = 1'b0; cpb = 8; jdp = 1'b1;
        src = '{8'hFF, 8'hFF}; src_idx = 0;
        @(posedge clk); #1;
        tx_pid = 4'b0011; tx_len = 7'd2; tx_start = 1'b1; drive_src();
        @(posedge clk); #1;
        tx_start = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            rdy = obs_rdy;
            @(posedge clk); #1;
            if (rdy) begin
                src_idx++;
                drive_src();
            end
        end
        n_cmp++;
        if (obs7[3] !== 1'b1) begin
            n_bad++; $display("FAIL mid_busy: got %b want 1", obs7[3]);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs7 !== 7'b1000000) begin
            n_bad++; $display("FAIL mid_reset: got %b want %b", obs7, 7'b1000000);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        src.delete(); src_idx = 0; drive_src();
        run_packet("after_reset", 4'b0010, 0, 0);
    endtask

    task automatic test_ls();
        sel = 1'b1; cpb = 4; jdp = 1'b0; src.delete();
        run_packet("ls_nak", 4'b1010, 0, 0);
        check_done_at("ls_nak", 77);
        sel = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end want finish");
        $fatal(1, "timeout");
    end

    initial begin
        cpb = 8; jdp = 1'b1;
        test_reset();
        test_ack();
        test_data_empty();
        test_stuffing();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_ls();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
